// File: rtl/fir_out_formatter_if.sv
// Output sample stream of the FIR formatter: show-ahead valid/ready with data and warm-up tag.
interface fir_out_formatter_if #(
  parameter int OUT_W = 16
);
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_data;
  logic                    m_warm;

  modport master (output m_valid, output m_data, output m_warm, input m_ready);
  modport slave  (input m_valid, input m_data, input m_warm, output m_ready);
endinterface

// File: rtl/fir_out_formatter.sv
// Captures FIR results one cycle after ena, rounds/shifts to OUT_W, tags warm-up samples and
// buffers them in a show-ahead FIFO. Clamping to the OUT_W range is enabled by `FIR_OUT_SAT_EN.
module fir_out_formatter #(
  parameter int N_TAPS     = 63,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic signed [IN_W-1:0]       y_in,
  fir_out_formatter_if.master          m,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         sat_flg,
  output logic                         drop_flg,
  input  logic                         flg_clr
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(N_TAPS + 1);
  localparam logic [WCW-1:0]         WARM_END = WCW'(N_TAPS - 1);
  localparam logic signed [IN_W:0]   HALF     = (IN_W+1)'(1) << (SHIFT - 1);

  // One guard bit keeps the rounding add from overflowing.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] y);
    logic signed [IN_W:0] sum;
    sum = $signed({y[IN_W-1], y}) + HALF;
    return sum >>> SHIFT;
  endfunction

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  function automatic logic signed [OUT_W-1:0] format_sample(input logic signed [IN_W:0] r);
    if (r > MAX_V) return {1'b0, {(OUT_W-1){1'b1}}};
    if (r < MIN_V) return {1'b1, {(OUT_W-1){1'b0}}};
    return r[OUT_W-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [IN_W:0] r);
    return (r > MAX_V) || (r < MIN_V);
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] format_sample(input logic signed [IN_W:0] r);
    return r[OUT_W-1:0];
  endfunction
`endif

  logic                    vld_p0;
  logic [WCW-1:0]          wcnt;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic signed [OUT_W-1:0] mem_data [FIFO_DEPTH];
  logic                    mem_warm [FIFO_DEPTH];
  logic signed [OUT_W-1:0] sample_p0;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign sample_p0 = format_sample(round_shift(y_in));
  assign full      = (level == LW'(FIFO_DEPTH));
  assign pop       = m.m_valid & m.m_ready;
  assign push      = vld_p0 & (~full | pop);
  assign drop      = vld_p0 & full & ~pop;

  // Stage p0: y_in belongs to the ena seen last cycle; control state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      wcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_flg <= 1'b0;
    end else begin
      vld_p0 <= ena;
      if (vld_p0 && wcnt != WARM_END) wcnt <= wcnt + WCW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      drop_flg <= (drop_flg & ~flg_clr) | drop;
    end
  end

`ifdef FIR_OUT_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flg <= 1'b0;
    else        sat_flg <= (sat_flg & ~flg_clr) | (vld_p0 & is_clamped(round_shift(y_in)));
  end
`else
  assign sat_flg = 1'b0;
`endif

  // Stage p1: FIFO storage, data only, no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sample_p0;
      mem_warm[wr_ptr] <= (wcnt < WARM_END);
    end
  end

  assign m.m_valid = (level != '0);
  assign m.m_data  = m.m_valid ? mem_data[rd_ptr] : '0;
  assign m.m_warm  = m.m_valid ? mem_warm[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_fir_out_formatter.sv
// Randomised and directed bench for fir_out_formatter against a queue-based sample model.
module tb_fir_out_formatter;
  localparam int N_TAPS = 63;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;
  localparam int DEPTH  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ena = 1'b0;
  logic                    flg_clr = 1'b0;
  logic signed [IN_W-1:0]  y_in = '0;
  logic [3:0]              level;
  logic                    sat_flg;
  logic                    drop_flg;

  fir_out_formatter_if #(.OUT_W(OUT_W)) bus ();

  fir_out_formatter #(
    .N_TAPS(N_TAPS), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .y_in(y_in), .m(bus),
    .level(level), .sat_flg(sat_flg), .drop_flg(drop_flg), .flg_clr(flg_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; logic warm; } samp_t;
  samp_t q[$];
  int    caps;
  bit    prev_ena;
  bit    m_sat;
  bit    m_drop;
  int    n_checks = 0;
  int    n_errors = 0;
  int    warm_pops;
  int    cold_pops;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Rounded, scaled sample as the filter output should read on the DAC side.
  function automatic logic [15:0] model_fmt(input logic signed [31:0] y, output bit clamped);
    longint r;
    r = floor_div(longint'(y) + 128, 256);
    clamped = 1'b0;
`ifdef FIR_OUT_SAT_EN
    if (r > 32767) begin r = 32767; clamped = 1'b1; end
    else if (r < -32768) begin r = -32768; clamped = 1'b1; end
`endif
    return r[15:0];
  endfunction

  task automatic check_outputs(input string tag);
    bit          ev;
    logic [15:0] ed;
    bit          ew;
    ev = (q.size() != 0);
    ed = ev ? q[0].data : 16'h0;
    ew = ev ? q[0].warm : 1'b0;
    check_val({tag, "_valid"}, {31'b0, bus.m_valid}, {31'b0, ev});
    check_val({tag, "_data"},  {16'h0, bus.m_data},  {16'h0, ed});
    check_val({tag, "_warm"},  {31'b0, bus.m_warm},  {31'b0, ew});
    check_val({tag, "_level"}, {28'h0, level},       32'(q.size()));
    check_val({tag, "_sat"},   {31'b0, sat_flg},     {31'b0, m_sat});
    check_val({tag, "_drop"},  {31'b0, drop_flg},    {31'b0, m_drop});
  endtask

  // Called just after a falling edge; applies inputs, advances the model, checks after the next rise.
  task automatic cycle(input bit e, input logic signed [31:0] y, input bit rdy, input bit clr);
    samp_t s;
    bit    cl;
    bit    sat_ev;
    bit    drop_ev;
    if (bus.m_valid && rdy) begin
      if (bus.m_warm) warm_pops++;
      else            cold_pops++;
    end
    ena = e; y_in = y; bus.m_ready = rdy; flg_clr = clr;
    sat_ev = 1'b0; drop_ev = 1'b0; cl = 1'b0;
    s.data = '0; s.warm = 1'b0;
    if (prev_ena) begin
      s.data = model_fmt(y, cl);
      s.warm = (caps < N_TAPS - 1);
      caps++;
      sat_ev = cl;
    end
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (prev_ena) begin
      if (q.size() < DEPTH) q.push_back(s);
      else drop_ev = 1'b1;
    end
    m_sat    = (m_sat && !clr) || sat_ev;
    m_drop   = (m_drop && !clr) || drop_ev;
    prev_ena = e;
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; ena = 1'b0; bus.m_ready = 1'b0; flg_clr = 1'b0;
    q.delete(); caps = 0; prev_ena = 1'b0; m_sat = 1'b0; m_drop = 1'b0;
    #1;
    check_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flush();
    for (int i = 0; i < 2 * DEPTH + 4 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("flush_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] t1_exp [4];
    logic [31:0] t5_exp [8];
    logic signed [31:0] yr;
    bus.m_ready = 1'b0;
    warm_pops = 0; cold_pops = 0;
    @(negedge clk);
    apply_reset();

    // T1: rounding
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 384, 1'b0, 1'b0);
    cycle(1'b1, -384, 1'b0, 1'b0);
    cycle(1'b1, 127, 1'b0, 1'b0);
    cycle(1'b0, 128, 1'b0, 1'b0);
    t1_exp = '{32'h2, 32'hFFFF, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      check_val("t1_round", {16'h0, bus.m_data}, t1_exp[i]);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end

    // T2: extremes
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h7FFFFFFF, 1'b0, 1'b0);
    cycle(1'b0, 32'h80000000, 1'b0, 1'b0);
`ifdef FIR_OUT_SAT_EN
    check_val("t2_max", {16'h0, bus.m_data}, 32'h7FFF);
    check_val("t2_satflg", {31'b0, sat_flg}, 32'h1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check_val("t2_min", {16'h0, bus.m_data}, 32'h8000);
`else
    check_val("t2_wrap_max", {16'h0, bus.m_data}, 32'h0);
    check_val("t2_satflg", {31'b0, sat_flg}, 32'h0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check_val("t2_wrap_min", {16'h0, bus.m_data}, 32'h0);
`endif
    flush();

    // T3: latency and warm-up tagging
    apply_reset();
    warm_pops = 0; cold_pops = 0;
    cycle(1'b1, $urandom(), 1'b1, 1'b0);
    check_val("t3_lat1", {31'b0, bus.m_valid}, 32'h0);
    cycle(1'b1, $urandom(), 1'b1, 1'b0);
    check_val("t3_lat2", {31'b0, bus.m_valid}, 32'h1);
    check_val("t3_first_warm", {31'b0, bus.m_warm}, 32'h1);
    for (int i = 0; i < 68; i++) cycle(1'b1, $urandom(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom(), 1'b1, 1'b0);
    check_val("t3_warm_cnt", 32'(warm_pops), 32'd62);
    check_val("t3_cold_cnt", 32'(cold_pops), 32'd8);

    // T4: overflow drops samples 9 and 10
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) cycle(k < 10, 256 * k, 1'b0, 1'b0);
    check_val("t4_level", {28'h0, level}, 32'd8);
    check_val("t4_drop", {31'b0, drop_flg}, 32'h1);
    check_val("t4_head", {16'h0, bus.m_data}, 32'd1);

    // T5: capture while full with a pop
    cycle(1'b1, 0, 1'b0, 1'b1);
    cycle(1'b0, 256 * 11, 1'b1, 1'b0);
    check_val("t5_level", {28'h0, level}, 32'd8);
    check_val("t5_drop", {31'b0, drop_flg}, 32'h0);
    t5_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd11};
    for (int i = 0; i < 8; i++) begin
      check_val("t5_drain", {16'h0, bus.m_data}, t5_exp[i]);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end

    // T6: mid-stream reset and flag-clear priority
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom(), 1'b0, 1'b0);
    apply_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    check_val("t6_warm_restart", {31'b0, bus.m_warm}, 32'h1);
`ifdef FIR_OUT_SAT_EN
    check_val("t6_set_wins", {31'b0, sat_flg}, 32'h1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check_val("t6_clr", {31'b0, sat_flg}, 32'h0);
`else
    check_val("t6_sat_tied", {31'b0, sat_flg}, 32'h0);
    cycle(1'b0, 0, 1'b1, 1'b1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       yr = 32'h7FFFFFFF;
        1:       yr = 32'h80000000;
        2:       yr = $urandom();
        default: yr = $signed($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
      endcase
      cycle($urandom_range(0, 3) != 0, yr, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
